// File: rtl/id_stage.sv
// RV32I decode stage: register file, immediate generator, control decode,
// load-use stall and the ID/EX register. Macro ID_WB_BYPASS_EN enables write-through reads.
module id_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instruction_in,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] PC_out,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic        reg_wen,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic        is_branch,
  output logic        is_jump,
  output logic        valid,
  output logic        illegal
);

  localparam logic [6:0] OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_JALR = 7'h67,
                         OP_STORE = 7'h23, OP_BRANCH = 7'h63, OP_LUI = 7'h37,
                         OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_REG = 7'h33;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            alu_src_a;
    logic            alu_src_b;
    logic [1:0]      wb_sel;
    logic            reg_wen;
    logic            mem_wen;
    logic            mem_ren;
    logic            is_branch;
    logic            is_jump;
    logic            valid;
    logic            illegal;
  } idex_t;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  idex_t           idex_q, idex_d, dec;

  logic [6:0]      opcode;
  logic [4:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            legal, uses_rs1, uses_rs2, hazard;

  assign opcode  = Instruction_in[6:0];
  // LUI carries immediate bits in the rs1 field; force x0 so it never aliases a real source.
  assign rs1_idx = (opcode == OP_LUI) ? 5'd0 : Instruction_in[19:15];
  assign rs2_idx = Instruction_in[24:20];

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd != 5'd0)) regs_d[wb_rd] = wb_data;
    regs_d[0] = '0;
  end

  always_comb begin
    rs1_val = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx];
    rs2_val = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) rs1_val = wb_data;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) rs2_val = wb_data;
`endif
  end

  always_comb begin
    dec          = '0;
    legal        = 1'b1;
    dec.pc       = PC_in;
    dec.rs1_data = rs1_val;
    dec.rs2_data = rs2_val;
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = Instruction_in[11:7];
    dec.funct3   = Instruction_in[14:12];
    dec.funct7b5 = Instruction_in[30];
    dec.valid    = 1'b1;
    case (opcode)
      OP_IMM: begin
        dec.imm = {{20{Instruction_in[31]}}, Instruction_in[31:20]};
        dec.alu_src_b = 1'b1; dec.reg_wen = 1'b1;
      end
      OP_LOAD: begin
        dec.imm = {{20{Instruction_in[31]}}, Instruction_in[31:20]};
        dec.alu_src_b = 1'b1; dec.reg_wen = 1'b1; dec.mem_ren = 1'b1; dec.wb_sel = 2'd1;
      end
      OP_JALR: begin
        dec.imm = {{20{Instruction_in[31]}}, Instruction_in[31:20]};
        dec.alu_src_b = 1'b1; dec.reg_wen = 1'b1; dec.wb_sel = 2'd2; dec.is_jump = 1'b1;
      end
      OP_STORE: begin
        dec.imm = {{20{Instruction_in[31]}}, Instruction_in[31:25], Instruction_in[11:7]};
        dec.alu_src_b = 1'b1; dec.mem_wen = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm = {{19{Instruction_in[31]}}, Instruction_in[31], Instruction_in[7],
                   Instruction_in[30:25], Instruction_in[11:8], 1'b0};
        dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.is_branch = 1'b1;
      end
      OP_LUI: begin
        dec.imm = {Instruction_in[31:12], 12'd0};
        dec.alu_src_b = 1'b1; dec.reg_wen = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = {Instruction_in[31:12], 12'd0};
        dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.reg_wen = 1'b1;
      end
      OP_JAL: begin
        dec.imm = {{11{Instruction_in[31]}}, Instruction_in[31], Instruction_in[19:12],
                   Instruction_in[20], Instruction_in[30:21], 1'b0};
        dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1; dec.reg_wen = 1'b1;
        dec.wb_sel = 2'd2; dec.is_jump = 1'b1;
      end
      OP_REG: dec.reg_wen = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  assign hazard   = idex_q.valid && idex_q.mem_ren && (idex_q.rd != 5'd0) &&
                    ((uses_rs1 && (rs1_idx == idex_q.rd)) || (uses_rs2 && (rs2_idx == idex_q.rd)));
  assign stall    = hazard && !flush && !reset;

  // Flush and hazard both squash to an all-zero bubble; an unknown opcode is a bubble tagged illegal.
  always_comb begin
    idex_d = dec;
    if (flush || hazard) begin
      idex_d = '0;
    end else if (!legal) begin
      idex_d         = '0;
      idex_d.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      idex_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      idex_q <= idex_d;
    end
  end

  assign PC_out    = idex_q.pc;
  assign rs1_data  = idex_q.rs1_data;
  assign rs2_data  = idex_q.rs2_data;
  assign imm       = idex_q.imm;
  assign rs1       = idex_q.rs1;
  assign rs2       = idex_q.rs2;
  assign rd        = idex_q.rd;
  assign funct3    = idex_q.funct3;
  assign funct7b5  = idex_q.funct7b5;
  assign alu_src_a = idex_q.alu_src_a;
  assign alu_src_b = idex_q.alu_src_b;
  assign wb_sel    = idex_q.wb_sel;
  assign reg_wen   = idex_q.reg_wen;
  assign mem_wen   = idex_q.mem_wen;
  assign mem_ren   = idex_q.mem_ren;
  assign is_branch = idex_q.is_branch;
  assign is_jump   = idex_q.is_jump;
  assign valid     = idex_q.valid;
  assign illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: hand-computed expectations checked by immediate assertions.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_in, Instruction_in, wb_data;
  logic        flush, wb_en;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] PC_out, rs1_data, rs2_data, imm;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic        funct7b5, alu_src_a, alu_src_b;
  logic [1:0]  wb_sel;
  logic        reg_wen, mem_wen, mem_ren, is_branch, is_jump, valid, illegal;

  int n_asserts = 0;
  int n_fail    = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .PC_in(PC_in), .Instruction_in(Instruction_in),
    .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .PC_out(PC_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7b5(funct7b5),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .wb_sel(wb_sel),
    .reg_wen(reg_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .is_branch(is_branch), .is_jump(is_jump), .valid(valid), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
    PC_in = pc;
    Instruction_in = ins;
    #1;
  endtask

  initial begin
    reset = 1'b1; PC_in = '0; Instruction_in = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_reg_wen", reg_wen, 0);
    check("rst_imm", imm, 0);
    check("rst_pc", PC_out, 0);
    check("rst_stall", stall, 0);

    // addi x1,x0,5 while writing x1 = 0x11
    reset = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h11;
    drive(32'h0, 32'h00500093);
    tick();
    wb_en = 1'b0;
    check("addi_valid", valid, 1);
    check("addi_rd", rd, 1);
    check("addi_imm", imm, 5);
    check("addi_srcb", alu_src_b, 1);
    check("addi_wen", reg_wen, 1);
    check("addi_rs1d", rs1_data, 0);
    check("addi_illegal", illegal, 0);

    // lw x2,0(x1)
    drive(32'h4, 32'h0000A103);
    check("lw_nostall", stall, 0);
    tick();
    check("lw_valid", valid, 1);
    check("lw_mren", mem_ren, 1);
    check("lw_wbsel", wb_sel, 1);
    check("lw_rd", rd, 2);
    check("lw_rs1d", rs1_data, 32'h11);

    // add x3,x2,x1: one-cycle load-use stall
    drive(32'h8, 32'h001101B3);
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_valid", valid, 0);
    check("lu_bubble_wen", reg_wen, 0);
    check("lu_stall_gone", stall, 0);
    tick();
    check("add_valid", valid, 1);
    check("add_rs1", rs1, 2);
    check("add_rs2", rs2, 1);
    check("add_rs2d", rs2_data, 32'h11);
    check("add_wen", reg_wen, 1);

    // Flush in the hazard cycle wins over the stall
    drive(32'hC, 32'h0000A103);
    tick();
    drive(32'h10, 32'h001101B3);
    flush = 1'b1; #1;
    check("fl_stall", stall, 0);
    tick();
    flush = 1'b0; #1;
    check("fl_valid", valid, 0);
    check("fl_nostall", stall, 0);
    tick();
    check("fl_add_valid", valid, 1);

    // jal ra,-4
    drive(32'h100, 32'hFFDFF0EF);
    tick();
    check("jal_imm", imm, 32'hFFFFFFFC);
    check("jal_jump", is_jump, 1);
    check("jal_wbsel", wb_sel, 2);
    check("jal_pc", PC_out, 32'h100);
    check("jal_rd", rd, 1);
    check("jal_srca", alu_src_a, 1);

    // addi x6,x5,0 with coincident writeback of x5
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    drive(32'h104, 32'h00028313);
    tick();
    wb_en = 1'b0;
`ifdef ID_WB_BYPASS_EN
    check("wb_same_cycle", rs1_data, 32'hDEADBEEF);
`else
    check("wb_same_cycle", rs1_data, 32'h0);
`endif
    tick();
    check("wb_next_read", rs1_data, 32'hDEADBEEF);

    // Write to x0 is dropped
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    drive(32'h108, 32'h00000313);
    tick();
    wb_en = 1'b0;
    check("x0_same_cycle", rs1_data, 0);
    tick();
    check("x0_next_read", rs1_data, 0);

    // Illegal opcode
    drive(32'h10C, 32'h0000007F);
    tick();
    check("ill_valid", valid, 0);
    check("ill_flag", illegal, 1);
    check("ill_wen", reg_wen, 0);
    check("ill_mwen", mem_wen, 0);
    check("ill_mren", mem_ren, 0);
    check("ill_jump", is_jump, 0);
    check("ill_branch", is_branch, 0);

    // sw x1,8(x0)
    drive(32'h110, 32'h00102423);
    tick();
    check("sw_imm", imm, 8);
    check("sw_mwen", mem_wen, 1);
    check("sw_wen", reg_wen, 0);
    check("sw_rs2d", rs2_data, 32'h11);
    check("sw_illegal", illegal, 0);

    // beq x1,x1,-8
    drive(32'h114, 32'hFE108CE3);
    tick();
    check("beq_imm", imm, 32'hFFFFFFF8);
    check("beq_branch", is_branch, 1);
    check("beq_srca", alu_src_a, 1);
    check("beq_srcb", alu_src_b, 1);
    check("beq_wen", reg_wen, 0);

    // lui x7,0x12345: rs1 field bits are immediate, index forced to 0
    drive(32'h118, 32'h123453B7);
    tick();
    check("lui_imm", imm, 32'h12345000);
    check("lui_rs1", rs1, 0);
    check("lui_srca", alu_src_a, 0);
    check("lui_rd", rd, 7);

    // Reset asserted during a load-use hazard
    drive(32'h11C, 32'h0000A103);
    tick();
    drive(32'h120, 32'h001101B3);
    check("pre_rst_stall", stall, 1);
    reset = 1'b1; #1;
    check("rst_mid_stall", stall, 0);
    tick();
    reset = 1'b0; #1;
    check("rst_mid_valid", valid, 0);
    check("rst_mid_nostall", stall, 0);
    tick();
    check("rst_resume_valid", valid, 1);
    check("rst_resume_rs2d", rs2_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I decode stage; sits directly downstream of the IF/ID register and consumes its PC and instruction.
- Contains the 32x32 register file, the immediate generator and the main control decoder.
- Contains load-use hazard detection driving a stall back to IF.
- Registers all decoded results into an internal ID/EX pipeline register that feeds EX.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- NREGS, 32, architectural register count; x0 hardwired to zero.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- PC_in  in  32  PC from IF/ID
- Instruction_in  in  32  instruction from IF/ID
- flush  in  1  taken branch/jump resolved in EX; squash the ID contents
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback data
- stall  out  1  combinational; IF must hold PC and IF/ID while high
- PC_out  out  32  registered PC
- rs1_data  out  32  registered rs1 value
- rs2_data  out  32  registered rs2 value
- imm  out  32  registered sign-extended immediate
- rs1  out  5  registered source index
- rs2  out  5  registered source index
- rd  out  5  registered destination index
- funct3  out  3  registered funct3
- funct7b5  out  1  registered Instruction[30]
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = imm
- wb_sel  out  2  0 = ALU, 1 = mem, 2 = PC+4
- reg_wen  out  1  registered control
- mem_wen  out  1  registered control
- mem_ren  out  1  registered control
- is_branch  out  1  registered control
- is_jump  out  1  registered control
- valid  out  1  ID/EX holds a real instruction
- illegal  out  1  registered; ID/EX slot came from an unknown opcode

Behaviour:
- Reset:
  - All ID/EX outputs go to 0; valid = 0.
  - All 32 registers clear to 0.
  - stall = 0 while reset is high.
- Latency: one cycle. Instruction present on Instruction_in at edge N appears decoded on the outputs after edge N.
- Register file:
  - Write on rising edge when wb_en = 1 and wb_rd != 0; writes to x0 are ignored.
  - Reads are combinational by index Instruction_in[19:15] and [24:20].
  - x0 always reads 0.
- Immediates:
  - I-type: opcodes 0x13, 0x03, 0x67.
  - S-type: 0x23.
  - B-type: 0x63.
  - U-type: 0x37, 0x17.
  - J-type: 0x6F.
  - R-type: 0x33, imm = 0.
  - All immediates sign-extend from Instruction[31].
- Control decode:
  - LUI: alu_src_a = 0 with rs1 index forced to 0.
  - AUIPC: alu_src_a = 1.
  - JAL, JALR: wb_sel = 2, is_jump = 1.
  - Loads: mem_ren = 1, wb_sel = 1.
  - Stores: mem_wen = 1, reg_wen = 0.
  - Branches: is_branch = 1, alu_src_a = 1, alu_src_b = 1, reg_wen = 0.
- Unknown opcode: bubble inserted (all controls 0, valid = 0) and illegal = 1 for that slot.
- Load-use hazard:
  - Detected when valid & mem_ren & (rd != 0) and the current instruction uses a source that matches rd.
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by R, S and B types.
  - On a hazard: stall = 1, and next-edge ID/EX gets a bubble (valid = 0, reg_wen = mem_wen = mem_ren = is_branch = is_jump = 0; data fields don't-care).
  - Stall lasts exactly one cycle, because the bubble clears the matching condition.
- Flush:
  - Next ID/EX is a bubble and stall is forced to 0.
  - Flush has priority over the hazard condition.
- Simultaneous writeback and read of the same register: see Optional Feature.
- Reset asserted mid-stall: reset wins; the pipeline resumes from the reset state.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined:
  - If wb_en & (wb_rd != 0) & (wb_rd == source index), the read port returns wb_data in the same cycle (write-through).
  - A writeback coincident with decode is therefore captured into rs1_data/rs2_data.
- Undefined:
  - Read ports return the old register contents.
  - The integration must resolve the same-cycle writeback hazard elsewhere (e.g. EX forwarding).

Test Plan:
- Reset:
  - Stimulus: hold reset 2 cycles, then Instruction_in = 0x00500093 (addi x1,x0,5).
  - Required after first edge: valid = 1, rd = 1, imm = 5, alu_src_b = 1, reg_wen = 1, rs1_data = 0.
- Load-use:
  - Stimulus: 0x0000A103 (lw x2,0(x1)), then 0x001101B3 (add x3,x2,x1).
  - Required: stall = 1 for exactly one cycle; ID/EX valid = 0 for that cycle; then add appears with rs1 = 2, rs2 = 1.
- Flush priority:
  - Stimulus: same lw/add hazard with flush = 1 in the hazard cycle.
  - Required: stall = 0 and next ID/EX valid = 0.
- JAL immediate:
  - Stimulus: 0xFFDFF0EF (jal ra,-4), PC_in = 0x100.
  - Required: imm = 0xFFFFFFFC, is_jump = 1, wb_sel = 2, PC_out = 0x100, rd = 1.
- Writeback:
  - Stimulus: wb_en = 1, wb_rd = 5, wb_data = 0xDEADBEEF while decoding a read of x5.
  - Required: rs1_data = 0xDEADBEEF with ID_WB_BYPASS_EN defined; old value without it; 0xDEADBEEF on the following read in both cases.
  - Also: a write to x0 leaves x0 reading 0.
- Illegal opcode:
  - Stimulus: Instruction_in = 0x0000007F.
  - Required: valid = 0, illegal = 1, all write/memory controls 0.
